// File: rtl/wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// cpu_defs
// Shared definitions for the LoongArch core pipeline back end:
//   - load operation encodings carried from MEM into WB
//   - GPR address and data widths
//   - WB stage FSM state encoding and the captured-instruction record
// -----------------------------------------------------------------------------
package cpu_defs;

  localparam int unsigned GPR_AW    = 5;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned LOAD_OP_W = 3;

  typedef enum logic [LOAD_OP_W-1:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_H  = 3'b010,
    LD_BU = 3'b011,
    LD_HU = 3'b100
  } load_op_e;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WAIT = 2'd1,
    WB_GO   = 2'd2
  } wb_state_e;

  // Instruction fields held by WB between capture and retirement.
  typedef struct packed {
    logic [DATA_W-1:0]    pc;
    logic                 gr_we;
    logic [GPR_AW-1:0]    dest;
    logic [DATA_W-1:0]    result;
    logic                 is_load;
    logic [LOAD_OP_W-1:0] load_op;
    logic [1:0]           addr_lo;
  } wb_fields_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Purely combinational load-data aligner: picks the addressed byte/halfword
// out of the 32-bit memory word and sign- or zero-extends it.
// Ports:
//   i_rdata   [31:0]  raw word returned by data memory
//   i_addr_lo [1:0]   load address bits [1:0]
//   i_load_op [2:0]   load operation (cpu_defs::load_op_e encoding)
//   o_data    [31:0]  extended value for the register file
// -----------------------------------------------------------------------------
module load_align
  import cpu_defs::*;
(
  input  logic [DATA_W-1:0]    i_rdata,
  input  logic [1:0]           i_addr_lo,
  input  logic [LOAD_OP_W-1:0] i_load_op,
  output logic [DATA_W-1:0]    o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    unique case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  // addr_lo[0] is don't-care for halfwords: misalignment is trapped in MEM.
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = i_rdata;
    case (i_load_op)
      LD_B:    o_data = {{24{w_byte[7]}}, w_byte};
      LD_BU:   o_data = {24'd0, w_byte};
      LD_H:    o_data = {{16{w_half[15]}}, w_half};
      LD_HU:   o_data = {16'd0, w_half};
      default: o_data = i_rdata;  // ld.w and undefined encodings
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Write-back stage of the 5-stage LoongArch core. Accepts one instruction per
// cycle from MEM, waits for load data when required, aligns/extends it and
// drives the register-file write port, the ID bypass bus, the difftest trace
// and a retired-instruction counter.
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   ms_to_ws_valid / ws_allowin  MEM->WB handshake
//   ms_pc, ms_gr_we, ms_dest, ms_result, ms_is_load, ms_load_op, ms_addr_lo
//                              instruction fields from MEM
//   data_sram_data_ok/rdata    load response (data_ok is a one-cycle pulse)
//   rf_we/waddr/wdata          register-file write port
//   ws_fwd_valid/dest/data/pending  bypass and load-use stall info for ID
//   debug_wb_pc/rf_we/rf_wnum/rf_wdata  difftest trace
//   ws_retire_cnt              retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module wb_stage
  import cpu_defs::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned TRACE_EN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ms_to_ws_valid,
  output logic                 ws_allowin,
  input  logic [DATA_W-1:0]    ms_pc,
  input  logic                 ms_gr_we,
  input  logic [GPR_AW-1:0]    ms_dest,
  input  logic [DATA_W-1:0]    ms_result,
  input  logic                 ms_is_load,
  input  logic [LOAD_OP_W-1:0] ms_load_op,
  input  logic [1:0]           ms_addr_lo,
  input  logic                 data_sram_data_ok,
  input  logic [DATA_W-1:0]    data_sram_rdata,
  output logic                 rf_we,
  output logic [GPR_AW-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 ws_fwd_valid,
  output logic [GPR_AW-1:0]    ws_fwd_dest,
  output logic [DATA_W-1:0]    ws_fwd_data,
  output logic                 ws_fwd_pending,
  output logic [DATA_W-1:0]    debug_wb_pc,
  output logic [3:0]           debug_wb_rf_we,
  output logic [GPR_AW-1:0]    debug_wb_rf_wnum,
  output logic [DATA_W-1:0]    debug_wb_rf_wdata,
  output logic [CNT_W-1:0]     ws_retire_cnt
);

  wb_state_e         r_state;
  wb_state_e         w_state_nxt;
  wb_fields_t        r_ws;
  logic [CNT_W-1:0]  r_retire_cnt;

  logic              w_valid;
  logic              w_ready_go;
  logic              w_capture;
  logic              w_retire;
  logic              w_writes_gpr;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_wdata;
  logic              w_rf_we;

  // The stage holds an instruction exactly when the FSM is out of IDLE.
  assign w_valid      = (r_state != WB_IDLE);
  // Load data is consumed straight off the bus in the data_ok cycle.
  assign w_ready_go   = (r_state == WB_GO) ||
                        ((r_state == WB_WAIT) && data_sram_data_ok);
  assign ws_allowin   = !w_valid || w_ready_go;
  assign w_capture    = ms_to_ws_valid && ws_allowin;
  assign w_retire     = w_valid && w_ready_go;
  assign w_writes_gpr = r_ws.gr_we && (r_ws.dest != '0);

  // ---------------------------------------------------------------------------
  // FSM state register and captured instruction fields
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= WB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ws <= '0;
    end else if (w_capture) begin
      r_ws.pc      <= ms_pc;
      r_ws.gr_we   <= ms_gr_we;
      r_ws.dest    <= ms_dest;
      r_ws.result  <= ms_result;
      r_ws.is_load <= ms_is_load;
      r_ws.load_op <= ms_load_op;
      r_ws.addr_lo <= ms_addr_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_retire_cnt <= '0;
    end else if (w_retire) begin
      r_retire_cnt <= r_retire_cnt + 1'b1;
    end
  end

  assign ws_retire_cnt = r_retire_cnt;

  // ---------------------------------------------------------------------------
  // Load alignment
  // ---------------------------------------------------------------------------
  load_align u_load_align (
    .i_rdata   (data_sram_rdata),
    .i_addr_lo (r_ws.addr_lo),
    .i_load_op (r_ws.load_op),
    .o_data    (w_load_data)
  );

  // ---------------------------------------------------------------------------
  // Next state and stage outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_wdata        = r_ws.result;
    w_rf_we        = 1'b0;
    ws_fwd_valid   = 1'b0;
    ws_fwd_pending = 1'b0;
    ws_fwd_dest    = '0;

    // A capture can coincide with a retire; allowin is low otherwise.
    if (w_capture) begin
      w_state_nxt = ms_is_load ? WB_WAIT : WB_GO;
    end else if (w_retire) begin
      w_state_nxt = WB_IDLE;
    end

    if (r_ws.is_load) begin
      w_wdata = w_load_data;
    end

    w_rf_we        = w_retire && w_writes_gpr;
    ws_fwd_valid   = w_rf_we;
    ws_fwd_pending = w_valid && w_writes_gpr &&
                     (r_state == WB_WAIT) && !data_sram_data_ok;
    if (w_valid) begin
      ws_fwd_dest = r_ws.dest;
    end
  end

  assign rf_we       = w_rf_we;
  assign rf_waddr    = r_ws.dest;
  assign rf_wdata    = w_wdata;
  assign ws_fwd_data = w_wdata;

  // ---------------------------------------------------------------------------
  // Difftest trace
  // ---------------------------------------------------------------------------
  if (TRACE_EN != 0) begin : g_trace
    assign debug_wb_pc       = w_valid ? r_ws.pc : '0;
    assign debug_wb_rf_we    = {4{w_rf_we}};
    assign debug_wb_rf_wnum  = r_ws.dest;
    assign debug_wb_rf_wdata = w_wdata;
  end else begin : g_no_trace
    assign debug_wb_pc       = '0;
    assign debug_wb_rf_we    = '0;
    assign debug_wb_rf_wnum  = '0;
    assign debug_wb_rf_wdata = '0;
  end

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Scoreboard bench for wb_stage: the driver pushes expected register writes as
// instructions are accepted; an independent monitor pops and compares on every
// register-file write.
// -----------------------------------------------------------------------------
module tb_wb_stage;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  logic        ms_is_load;
  logic [2:0]  ms_load_op;
  logic [1:0]  ms_addr_lo;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_fwd_valid;
  logic [4:0]  ws_fwd_dest;
  logic [31:0] ws_fwd_data;
  logic        ws_fwd_pending;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] ws_retire_cnt;

  always #5 clk = ~clk;

  wb_stage #(.CNT_W(32), .TRACE_EN(1)) dut (
    .clk               (clk),
    .reset             (reset),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ws_allowin        (ws_allowin),
    .ms_pc             (ms_pc),
    .ms_gr_we          (ms_gr_we),
    .ms_dest           (ms_dest),
    .ms_result         (ms_result),
    .ms_is_load        (ms_is_load),
    .ms_load_op        (ms_load_op),
    .ms_addr_lo        (ms_addr_lo),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ws_fwd_valid      (ws_fwd_valid),
    .ws_fwd_dest       (ws_fwd_dest),
    .ws_fwd_data       (ws_fwd_data),
    .ws_fwd_pending    (ws_fwd_pending),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .ws_retire_cnt     (ws_retire_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        is_load;
    logic [2:0]  op;
    logic [1:0]  addr;
    logic [31:0] rdata;
    int unsigned delay;
  } instr_t;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Driver-side view of the outstanding load.
  bit          waiting   = 1'b0;
  int unsigned wait_left = 0;
  logic [31:0] wait_rdata = '0;
  bit          wait_wnz  = 1'b0;
  int unsigned issued    = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // Reference load semantics: shift the addressed unit to the top of the word,
  // then shift back down arithmetically (signed) or logically (unsigned).
  function automatic logic [31:0] ref_load(logic [31:0] rd, logic [2:0] op, logic [1:0] a);
    int unsigned lo_b = 8 * int'(a);
    int unsigned lo_h = 8 * (int'(a) & 2);
    logic [31:0] up;
    case (op)
      3'd1: begin up = rd << (24 - lo_b); return 32'($signed(up) >>> 24); end
      3'd3: return (rd >> lo_b) & 32'h0000_00FF;
      3'd2: begin up = rd << (16 - lo_h); return 32'($signed(up) >>> 16); end
      3'd4: return (rd >> lo_h) & 32'h0000_FFFF;
      default: return rd;
    endcase
  endfunction

  function automatic instr_t mk(logic [31:0] pc, logic we, logic [4:0] dest,
                                logic [31:0] result, logic is_load, logic [2:0] op,
                                logic [1:0] addr, logic [31:0] rdata, int unsigned delay);
    instr_t i;
    i.pc = pc; i.we = we; i.dest = dest; i.result = result; i.is_load = is_load;
    i.op = op; i.addr = addr; i.rdata = rdata; i.delay = delay;
    return i;
  endfunction

  function automatic instr_t rnd_instr();
    instr_t i;
    i.pc      = $urandom() & 32'hFFFF_FFFC;
    i.we      = ($urandom_range(0, 3) != 0);
    i.dest    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    i.result  = $urandom();
    i.is_load = ($urandom_range(0, 9) < 4);
    i.op      = 3'($urandom_range(0, 7));
    i.addr    = 2'($urandom_range(0, 3));
    i.rdata   = $urandom();
    i.delay   = $urandom_range(0, 3);
    return i;
  endfunction

  // One clock cycle of stimulus, entered and left at posedge+1.
  task automatic step(input bit present, input instr_t ins, input bit spurious);
    bit   dok;
    bit   pres;
    logic exp_allow;
    logic exp_pend;
    dok       = waiting ? (wait_left == 0) : spurious;
    exp_allow = !(waiting && !dok);
    exp_pend  = waiting && !dok && wait_wnz;
    pres      = present && exp_allow;
    data_sram_data_ok = dok;
    data_sram_rdata   = waiting ? wait_rdata : $urandom();
    ms_to_ws_valid = pres;
    ms_pc      = ins.pc;
    ms_gr_we   = ins.we;
    ms_dest    = ins.dest;
    ms_result  = ins.result;
    ms_is_load = ins.is_load;
    ms_load_op = ins.op;
    ms_addr_lo = ins.addr;
    if (pres) begin
      issued++;
      if (ins.we && ins.dest != 5'd0)
        q.push_back('{ins.pc, ins.dest,
                      ins.is_load ? ref_load(ins.rdata, ins.op, ins.addr) : ins.result});
    end
    @(negedge clk);
    chk("allowin", 32'(ws_allowin), 32'(exp_allow));
    chk("fwd_pending", 32'(ws_fwd_pending), 32'(exp_pend));
    @(posedge clk); #1;
    if (waiting) begin
      if (dok) waiting = 1'b0;
      else wait_left--;
    end
    if (pres && ins.is_load) begin
      waiting    = 1'b1;
      wait_left  = ins.delay;
      wait_rdata = ins.rdata;
      wait_wnz   = ins.we && (ins.dest != 5'd0);
    end
    ms_to_ws_valid    = 1'b0;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic idle_step();
    instr_t z;
    z = mk('0, 0, 0, '0, 0, 0, 0, '0, 0);
    step(1'b0, z, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 16 && waiting; k++) idle_step();
    idle_step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ms_to_ws_valid    = 1'b0;
    data_sram_data_ok = 1'b0;
    @(posedge clk); #1;
    reset   = 1'b0;
    waiting = 1'b0;
    q.delete();
    issued  = 0;
  endtask

  // Monitor: every register-file write must match the oldest expectation.
  always @(negedge clk) begin
    if (rf_we) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got write to r%0d data 0x%08h expected no write",
                 rf_waddr, rf_wdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rf_waddr", 32'(rf_waddr), 32'(e.dest));
        chk("rf_wdata", rf_wdata, e.data);
        chk("debug_pc", debug_wb_pc, e.pc);
        chk("fwd_valid", 32'(ws_fwd_valid), 32'd1);
        chk("fwd_dest", 32'(ws_fwd_dest), 32'(e.dest));
        chk("fwd_data", ws_fwd_data, e.data);
        chk("dbg_rf_we", 32'(debug_wb_rf_we), 32'hF);
        chk("dbg_wnum", 32'(debug_wb_rf_wnum), 32'(e.dest));
        chk("dbg_wdata", debug_wb_rf_wdata, e.data);
      end
    end else begin
      chk("fwd_valid_nowrite", 32'(ws_fwd_valid), 32'd0);
      chk("dbg_rf_we_nowrite", 32'(debug_wb_rf_we), 32'd0);
    end
  end

  initial begin
    reset = 1'b1;
    ms_to_ws_valid = 1'b0; ms_pc = '0; ms_gr_we = 1'b0; ms_dest = '0;
    ms_result = '0; ms_is_load = 1'b0; ms_load_op = '0; ms_addr_lo = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_allowin", 32'(ws_allowin), 32'd1);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_fwd_dest", 32'(ws_fwd_dest), 32'd0);
    chk("rst_fwd_pending", 32'(ws_fwd_pending), 32'd0);
    chk("rst_debug_pc", debug_wb_pc, 32'd0);
    chk("rst_cnt", ws_retire_cnt, 32'd0);
    @(posedge clk); #1;
    do_reset();

    // Plain ALU write.
    step(1'b1, mk(32'h1c00_0000, 1, 5, 32'h1234_5678, 0, 0, 0, '0, 0), 1'b0);
    drain();
    chk("cnt_single", ws_retire_cnt, 32'd1);

    // ld.b with data_ok three cycles after capture.
    do_reset();
    step(1'b1, mk(32'h1c00_0010, 1, 7, 32'hDEAD_BEEF, 1, 3'd1, 2, 32'h0080_0000, 2), 1'b0);
    drain();
    chk("cnt_load_wait", ws_retire_cnt, 32'd1);

    // Extraction sweep, back-to-back loads with immediate data.
    do_reset();
    step(1'b1, mk(32'h100, 1, 1, '0, 1, 3'd4, 2, 32'h8001_7FFE, 0), 1'b0);
    step(1'b1, mk(32'h104, 1, 2, '0, 1, 3'd2, 0, 32'h8001_7FFE, 0), 1'b0);
    step(1'b1, mk(32'h108, 1, 3, '0, 1, 3'd3, 3, 32'h8001_7FFE, 0), 1'b0);
    step(1'b1, mk(32'h10c, 1, 4, '0, 1, 3'd0, 1, 32'h8001_7FFE, 0), 1'b0);
    step(1'b1, mk(32'h110, 1, 6, '0, 1, 3'd7, 1, 32'h8001_7FFE, 1), 1'b0);
    drain();
    chk("cnt_sweep", ws_retire_cnt, 32'd5);

    // dest = r0 never writes but still retires.
    do_reset();
    step(1'b1, mk(32'h200, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, '0, 0), 1'b0);
    drain();
    chk("cnt_r0", ws_retire_cnt, 32'd1);

    // Four consecutive non-loads, spurious data_ok in the middle.
    do_reset();
    for (int k = 0; k < 4; k++)
      step(1'b1, mk(32'h300 + 32'(4 * k), 1, 5'(8 + k), 32'hA000_0000 + 32'(k), 0, 0, 0, '0, 0),
           (k == 1) || (k == 2));
    drain();
    chk("cnt_b2b", ws_retire_cnt, 32'd4);

    // Reset while WAIT, then a late data_ok.
    do_reset();
    step(1'b1, mk(32'h400, 1, 3, '0, 1, 3'd0, 0, 32'h5555_AAAA, 5), 1'b0);
    idle_step();
    reset = 1'b1;
    @(posedge clk); #1;
    reset   = 1'b0;
    waiting = 1'b0;
    q.delete();
    issued  = 0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h5555_AAAA;
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    chk("flush_cnt", ws_retire_cnt, 32'd0);
    chk("flush_allowin", 32'(ws_allowin), 32'd1);
    chk("flush_debug_pc", debug_wb_pc, 32'd0);
    @(posedge clk); #1;

    // Randomized traffic.
    do_reset();
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 9) < 7, rnd_instr(), $urandom_range(0, 9) == 0);
    drain();
    chk("cnt_random", ws_retire_cnt, 32'(issued));
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
